grom_io_capture: RTL and testbench

//   Parametrised I/O output capture port for grom_cpu. Decodes CPU I/O writes
//   (ioreq=1, we=1) to NUM_PORTS consecutive I/O addresses and queues
//   {channel, byte} entries in a shared FIFO. A valid/ready drain side feeds a

---
 rtl/grom_io_capture.sv | 141 ++++++++++++++
 tb/tb_grom_io_capture.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/grom_io_capture.sv
// grom_io_capture: I/O output capture port for grom_cpu.
//
// CPU I/O writes to NUM_PORTS consecutive addresses starting at BASE_ADDR are
// queued as {channel, byte} entries in a shared FIFO. The FIFO head is drained
// through a valid/ready interface. A status register at BASE_ADDR+NUM_PORTS
// reports {full, empty, overflow, count[4:0]}. Writing it clears the sticky
// overflow flag (bit 5) and/or flushes the FIFO (bit 0).
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   addr       CPU address bus (12 bits)
//   data_in    CPU write data
//   data_out   status read data; 8'h00 unless this is a status read cycle
//   we         CPU write enable
//   ioreq      CPU I/O request; memory cycles are ignored
//   out_valid  FIFO head valid
//   out_ready  consumer accepts the head entry
//   out_chan   channel index of the head entry
//   out_data   data byte of the head entry
//   overflow   sticky flag: a write was dropped because the FIFO was full

module grom_io_capture #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 8,
  localparam int unsigned CHW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [11:0]    addr,
  input  logic [7:0]     data_in,
  output logic [7:0]     data_out,
  input  logic           we,
  input  logic           ioreq,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_chan,
  output logic [7:0]     out_data,
  output logic           overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = CHW + 8;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic [11:0]    offset;
  logic           in_range, is_stat;
  logic [CHW-1:0] chan;
  logic           full, empty;
  logic           push, pop, do_push, stat_wr, flush, ovf_set, ovf_clr;
  logic [EW-1:0]  head;

  // Offset from the base; an address below the base wraps to a large value
  // and so falls outside both the channel window and the status address.
  assign offset   = addr - BASE_ADDR;
  assign in_range = offset < 12'(NUM_PORTS);
  assign is_stat  = offset == 12'(NUM_PORTS);
  assign chan     = offset[CHW-1:0];

  assign full  = (count_q == 5'(DEPTH));
  assign empty = (count_q == 5'd0);

  assign push    = ioreq & we & in_range;
  assign stat_wr = ioreq & we & is_stat;
  assign flush   = stat_wr & data_in[0];
  assign pop     = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | pop) & ~flush;
  assign ovf_set = push & full & ~pop;
  assign ovf_clr = stat_wr & data_in[5];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({do_push, pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Set has priority over clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {chan, data_in};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_chan  = head[EW-1:8];
  assign out_data  = head[7:0];
  assign out_valid = ~empty;
  assign overflow  = overflow_q;

  always_comb begin
    data_out = 8'h00;
    if (ioreq && !we && is_stat) begin
      data_out = {full, empty, overflow_q, count_q};
    end
  end

endmodule

// File: tb/tb_grom_io_capture.sv
module tb_grom_io_capture;

  localparam logic [11:0] BASE  = 12'h000;
  localparam int          NP    = 4;
  localparam int          DEPTH = 8;
  localparam logic [11:0] STAT  = BASE + 12'(NP);

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] addr;
  logic [7:0]  data_in, data_out;
  logic        we, ioreq, out_valid, out_ready, overflow;
  logic [1:0]  out_chan;
  logic [7:0]  out_data;

  grom_io_capture #(
    .BASE_ADDR(BASE),
    .NUM_PORTS(NP),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .we       (we),
    .ioreq    (ioreq),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan (out_chan),
    .out_data (out_data),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } ent_t;

  // Expected FIFO contents in order; the monitor consumes from the front.
  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_count = 0;
  bit   m_ovf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT presents a head, it must match the oldest
  // expected entry; it is consumed when the handshake completes.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_head: got (%0h,%0h) expected nothing", out_chan, out_data);
      end else begin
        chk("head_chan", 32'(out_chan), 32'(sb[0].ch));
        chk("head_data", 32'(out_data), 32'(sb[0].d));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One bus cycle, entered just after a rising edge and left just after the next.
  task automatic cyc(input bit io, input bit w, input logic [11:0] a, input logic [7:0] d,
                     input bit rdy);
    bit push, pop, full, swr;
    ioreq = io; we = w; addr = a; data_in = d; out_ready = rdy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_count != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (io && !w && a == STAT)
      chk("status", 32'(data_out),
          32'({m_count == DEPTH, m_count == 0, m_ovf, 5'(m_count)}));
    else
      chk("data_out_idle", 32'(data_out), 32'h0);
    push = io && w && (a >= BASE) && (a < STAT);
    swr  = io && w && (a == STAT);
    full = (m_count == DEPTH);
    pop  = (m_count != 0) && rdy;
    @(posedge clk);
    if (swr && d[0]) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (pop) m_count--;
      if (push && (!full || pop)) begin
        sb.push_back('{ch: 2'(a - BASE), d: d});
        m_count++;
      end
    end
    if (push && full && !pop) m_ovf = 1'b1;
    else if (swr && d[5]) m_ovf = 1'b0;
    #1;
  endtask

  task automatic status_rd(input bit rdy);
    cyc(1'b1, 1'b0, STAT, 8'h00, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_count != 0; i++) cyc(1'b0, 1'b0, 12'h0, 8'h0, 1'b1);
    cyc(1'b0, 1'b0, 12'h0, 8'h0, 1'b1);
    chk("drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; ioreq = 1'b0; we = 1'b0; addr = '0; data_in = '0; out_ready = 1'b0;
    #12;
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    status_rd(1'b0);

    // Two writes drained in order.
    cyc(1'b1, 1'b1, BASE + 12'd0, 8'hA5, 1'b1);
    cyc(1'b1, 1'b1, BASE + 12'd2, 8'h3C, 1'b1);
    drain();

    // Nine writes into a stalled FIFO; the ninth is dropped.
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b1, BASE + 12'd1, 8'(i), 1'b0);
    status_rd(1'b0);
    drain();

    // Flush plus overflow clear while holding three entries.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, BASE + 12'(i), 8'h50 + 8'(i), 1'b0);
    cyc(1'b1, 1'b1, STAT, 8'h21, 1'b0);
    status_rd(1'b0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, BASE + 12'(i % NP), 8'h10 + 8'(i), 1'b0);
    cyc(1'b1, 1'b1, BASE + 12'd3, 8'hEE, 1'b1);
    status_rd(1'b0);
    drain();

    // Memory cycle and out-of-range I/O address.
    cyc(1'b0, 1'b1, BASE, 8'h77, 1'b0);
    cyc(1'b1, 1'b1, BASE + 12'd5, 8'h78, 1'b0);
    cyc(1'b1, 1'b1, 12'hFFF, 8'h79, 1'b0);
    status_rd(1'b0);

    // Asynchronous reset with five entries pending.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, BASE + 12'd2, 8'hC0 + 8'(i), 1'b0);
    ioreq = 1'b1; we = 1'b0; addr = STAT; out_ready = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_status", 32'(data_out), 32'h40);
    sb.delete();
    m_count = 0;
    m_ovf = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, BASE + 12'd1, 8'h9A, 1'b0);
    cyc(1'b1, 1'b1, BASE + 12'd3, 8'h9B, 1'b0);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      bit          io, w, rdy;
      logic [11:0] a;
      logic [7:0]  d;
      io  = ($urandom % 4) != 0;
      w   = ($urandom % 4) != 0;
      rdy = ($urandom % 3) == 0;
      a   = ($urandom % 8 == 0) ? 12'($urandom) : BASE + 12'($urandom_range(0, NP + 1));
      d   = 8'($urandom);
      if (a == STAT && w && ($urandom % 8) != 0) d[0] = 1'b0;
      cyc(io, w, a, d, rdy);
      if (i % 50 == 0) status_rd(1'b0);
    end
    drain();
    status_rd(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
